// File: rtl/inputc_vc_pkg.sv
// Shared flit format, VC geometry and flit-type helpers for the router input channel.
package inputc_vc_pkg;

  localparam int DATAW    = 31;
  localparam int DATAW_P1 = DATAW + 1;
  localparam int VCH      = 1;
  localparam int VCHW     = 0;
  localparam int VCHW_P1  = VCHW + 1;

  localparam int TYPEW    = 3;
  localparam int TYPE_MSB = DATAW;
  localparam int TYPE_LSB = DATAW - TYPEW + 1;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [TYPEW-1:0] {
    TYPE_NONE     = 3'd0,
    TYPE_HEAD     = 3'd1,
    TYPE_BODY     = 3'd2,
    TYPE_TAIL     = 3'd3,
    TYPE_HEADTAIL = 3'd4
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } sel_state_e;

  function automatic logic is_head(input logic [DATAW:0] flit);
    logic [TYPEW-1:0] t;
    t = flit[TYPE_MSB:TYPE_LSB];
    return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
  endfunction

  function automatic logic is_tail(input logic [DATAW:0] flit);
    logic [TYPEW-1:0] t;
    t = flit[TYPE_MSB:TYPE_LSB];
    return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/inputc_vc_fifo.sv
// Per-VC flit FIFO; a push into a full FIFO only lands when a pop frees a slot in the same cycle.
module vc_fifo #(
  parameter  int FIFOD = 4,
  parameter  int W     = 32,
  localparam int AW    = $clog2(FIFOD),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [FIFOD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(FIFOD));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/inputc_vc.sv
// Router input channel: per-VC buffering, credit acks, lock reporting and wormhole VC selection.
module inputc_vc
  import inputc_vc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int FIFOD    = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATAW:0]    idata,
  input  logic              ivalid,
  input  logic [VCHW:0]     ivch,
  output logic [VCH:0]      oack,
  output logic [VCH:0]      olck,
  output logic [DATAW:0]    odata,
  output logic              ovalid,
  output logic [VCHW:0]     ovch,
  input  logic              irdy,
  output logic              oerr
);

  localparam int NVC = VCH + 1;
  localparam int CW  = $clog2(FIFOD) + 1;

  logic [NVC-1:0] push, pop, full, empty;
  logic [NVC-1:0] lock_set, lock_clr;
  logic [DATAW:0] fifo_dout [NVC];
  logic [CW-1:0]  count_unused [NVC];
  logic [63:0]    unused_ids;

  sel_state_e     state_q;
  logic [VCHW:0]  hold_vc_q, last_q, sel_vc, cand;
  logic           sel_ok, pop_any, pop_tail;
  logic [DATAW:0] pop_data;

  logic [VCH:0]   olck_q, olck_d, oack_q;
  logic [DATAW:0] odata_q;
  logic [VCHW:0]  ovch_q;
  logic           ovalid_q, oerr_q, oerr_d;

  // Identifiers have no functional role; kept visible for debug only.
  assign unused_ids = {32'(ROUTERID), 32'(PCHID)};

  for (genvar gi = 0; gi < NVC; gi++) begin : g_vc
    assign push[gi]     = ivalid && (ivch == VCHW_P1'(gi));
    assign pop[gi]      = pop_any && (sel_vc == VCHW_P1'(gi));
    assign lock_set[gi] = push[gi] && (!full[gi] || pop[gi]) && is_head(idata);
    assign lock_clr[gi] = pop[gi] && pop_tail;

    vc_fifo #(
      .FIFOD (FIFOD),
      .W     (DATAW_P1)
    ) u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (idata),
      .dout  (fifo_dout[gi]),
      .count (count_unused[gi]),
      .full  (full[gi]),
      .empty (empty[gi])
    );
  end

  // In IDLE, scan round-robin starting just after the last granted VC.
  always_comb begin
    sel_vc = hold_vc_q;
    sel_ok = 1'b0;
    cand   = '0;
    if (state_q == ST_HOLD) begin
      sel_ok = !empty[hold_vc_q];
    end else begin
      for (int k = 1; k <= NVC; k++) begin
        cand = last_q + VCHW_P1'(k);
        if (!sel_ok && !empty[cand]) begin
          sel_vc = cand;
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign pop_any  = sel_ok && irdy;
  assign pop_data = fifo_dout[sel_vc];
  assign pop_tail = is_tail(pop_data);

  assign olck_d = (olck_q & ~lock_clr) | lock_set;
  assign oerr_d = oerr_q | (ivalid && full[ivch] && !pop[ivch]);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q   <= ST_IDLE;
      hold_vc_q <= '0;
      last_q    <= '0;
      oack_q    <= '0;
      ovalid_q  <= 1'b0;
      odata_q   <= '0;
      ovch_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_ok) begin
            last_q    <= sel_vc;
            hold_vc_q <= sel_vc;
            if (!(pop_any && pop_tail)) state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (pop_any && pop_tail) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      oack_q   <= pop;
      ovalid_q <= pop_any;
      odata_q  <= pop_any ? pop_data : '0;
      ovch_q   <= pop_any ? sel_vc : '0;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      olck_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      olck_q <= olck_d;
      oerr_q <= oerr_d;
    end
  end

  assign oack   = oack_q;
  assign olck   = olck_q;
  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;
  assign oerr   = oerr_q;

endmodule

// File: tb/tb_inputc_vc.sv
// Scenario bench for inputc_vc: scoreboard of expected output flits plus per-scenario timing checks.
module tb_inputc_vc;
  import inputc_vc_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        vc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic [31:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic [1:0]  oack;
  logic [1:0]  olck;
  logic [31:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic        irdy;
  logic        oerr;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  inputc_vc #(.ROUTERID(0), .PCHID(0), .FIFOD(4)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .idata  (idata),
    .ivalid (ivalid),
    .ivch   (ivch),
    .oack   (oack),
    .olck   (olck),
    .odata  (odata),
    .ovalid (ovalid),
    .ovch   (ovch),
    .irdy   (irdy),
    .oerr   (oerr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [28:0] p);
    return {t, p};
  endfunction

  // Scoreboard: every output cycle is checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (ovalid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out odata=%h ovch=%0d (no flit expected)", odata, ovch);
      end else begin
        e = sb.pop_front();
        if (odata !== e.data || ovch !== e.vc) begin
          n_err++;
          $display("FAIL out_flit odata=%h ovch=%0d expected odata=%h ovch=%0d", odata, ovch, e.data, e.vc);
        end else begin
          $display("out flit odata=%h ovch=%0d", odata, ovch);
        end
      end
      n_vec++;
      if (oack !== (2'b01 << ovch)) begin
        n_err++;
        $display("FAIL out_ack oack=%b expected %b", oack, 2'b01 << ovch);
      end
    end else begin
      n_vec++;
      if (oack !== 2'b00 || odata !== 32'h0 || ovch !== 1'b0 || ovalid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_out ovalid=%b oack=%b odata=%h ovch=%0d expected all zero", ovalid, oack, odata, ovch);
      end
    end
  end

  task automatic send(input logic v, input logic [2:0] t, input logic [28:0] p, input bit exp_out);
    exp_t e;
    ivalid = 1'b1;
    ivch   = v;
    idata  = mk(t, p);
    if (exp_out) begin
      e.data = mk(t, p);
      e.vc   = v;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
  endtask

  task automatic expect_flit(input logic v, input logic [2:0] t, input logic [28:0] p);
    exp_t e;
    e.data = mk(t, p);
    e.vc   = v;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain pending=%0d expected 0 within 60 cycles", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_   = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
    irdy   = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (olck !== 2'b00 || oerr !== 1'b0 || ovalid !== 1'b0 || oack !== 2'b00 || odata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state olck=%b oerr=%b ovalid=%b oack=%b odata=%h expected zeros", olck, oerr, ovalid, oack, odata);
    end
    rst_ = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    irdy = 1'b1;
    send(1'b0, TYPE_HEADTAIL, 29'hA5, 1'b1);
    n_vec++;
    if (olck[0] !== 1'b1 || ovalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_lock olck0=%b ovalid=%b expected 1 0", olck[0], ovalid);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (ovalid !== 1'b1 || odata !== mk(TYPE_HEADTAIL, 29'hA5) || ovch !== 1'b0 || oack !== 2'b01) begin
      n_err++;
      $display("FAIL single_out ovalid=%b odata=%h ovch=%0d oack=%b expected 1 %h 0 01",
               ovalid, odata, ovch, oack, mk(TYPE_HEADTAIL, 29'hA5));
    end
    n_vec++;
    if (olck[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single_unlock olck0=%b expected 0", olck[0]);
    end
    wait_drain("single");
  endtask

  task automatic test_stall();
    int acks = 0;
    irdy = 1'b0;
    send(1'b1, TYPE_HEAD, 29'h11, 1'b1);
    send(1'b1, TYPE_BODY, 29'h12, 1'b1);
    send(1'b1, TYPE_TAIL, 29'h13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (ovalid !== 1'b0 || oack !== 2'b00) begin
        n_err++;
        $display("FAIL stall_quiet cycle=%0d ovalid=%b oack=%b expected 0 00", i, ovalid, oack);
      end
    end
    n_vec++;
    if (olck[1] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_lock olck1=%b expected 1", olck[1]);
    end
    irdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (oack[1] === 1'b1) acks++;
      if (i < 3) begin
        n_vec++;
        if (ovalid !== 1'b1 || ovch !== 1'b1) begin
          n_err++;
          $display("FAIL stall_burst cycle=%0d ovalid=%b ovch=%0d expected 1 1", i, ovalid, ovch);
        end
        n_vec++;
        if (olck[1] !== (i < 2 ? 1'b1 : 1'b0)) begin
          n_err++;
          $display("FAIL stall_lock_clear cycle=%0d olck1=%b expected %b", i, olck[1], (i < 2 ? 1'b1 : 1'b0));
        end
      end
    end
    n_vec++;
    if (acks != 3) begin
      n_err++;
      $display("FAIL stall_acks count=%0d expected 3", acks);
    end
    wait_drain("stall");
  endtask

  task automatic test_interleave();
    irdy = 1'b1;
    expect_flit(1'b0, TYPE_HEAD, 29'h21);
    expect_flit(1'b0, TYPE_BODY, 29'h22);
    expect_flit(1'b0, TYPE_TAIL, 29'h23);
    expect_flit(1'b1, TYPE_HEAD, 29'h31);
    expect_flit(1'b1, TYPE_TAIL, 29'h32);
    send(1'b0, TYPE_HEAD, 29'h21, 1'b0);
    send(1'b1, TYPE_HEAD, 29'h31, 1'b0);
    send(1'b0, TYPE_BODY, 29'h22, 1'b0);
    send(1'b1, TYPE_TAIL, 29'h32, 1'b0);
    send(1'b0, TYPE_TAIL, 29'h23, 1'b0);
    wait_drain("interleave");
    // Two VC0 packets and one VC1 packet pending: rotation must visit VC1 between them.
    irdy = 1'b0;
    send(1'b0, TYPE_HEADTAIL, 29'h41, 1'b0);
    send(1'b0, TYPE_HEADTAIL, 29'h42, 1'b0);
    send(1'b1, TYPE_HEADTAIL, 29'h43, 1'b0);
    expect_flit(1'b0, TYPE_HEADTAIL, 29'h41);
    expect_flit(1'b1, TYPE_HEADTAIL, 29'h43);
    expect_flit(1'b0, TYPE_HEADTAIL, 29'h42);
    irdy = 1'b1;
    wait_drain("round_robin");
  endtask

  task automatic test_overflow();
    int acks = 0;
    irdy = 1'b0;
    send(1'b0, TYPE_HEAD, 29'h51, 1'b1);
    send(1'b0, TYPE_BODY, 29'h52, 1'b1);
    send(1'b0, TYPE_BODY, 29'h53, 1'b1);
    send(1'b0, TYPE_TAIL, 29'h54, 1'b1);
    n_vec++;
    if (oerr !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_pre oerr=%b expected 0", oerr);
    end
    send(1'b0, TYPE_HEADTAIL, 29'h55, 1'b0);
    n_vec++;
    if (oerr !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_flag oerr=%b expected 1", oerr);
    end
    irdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (oack[0] === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 4 || oerr !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_drain acks=%0d oerr=%b expected 4 1", acks, oerr);
    end
    wait_drain("overflow");
  endtask

  task automatic test_full_wrap();
    irdy = 1'b0;
    send(1'b0, TYPE_HEAD, 29'h100, 1'b1);
    for (int i = 1; i < 4; i++) send(1'b0, TYPE_BODY, 29'(32'h100 + i), 1'b1);
    irdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, (i == 7) ? TYPE_TAIL : TYPE_BODY, 29'(32'h104 + i), 1'b1);
      n_vec++;
      if (ovalid !== 1'b1 || oerr !== 1'b0) begin
        n_err++;
        $display("FAIL full_wrap cycle=%0d ovalid=%b oerr=%b expected 1 0", i, ovalid, oerr);
      end
    end
    wait_drain("full_wrap");
    n_vec++;
    if (olck[0] !== 1'b0 || oerr !== 1'b0) begin
      n_err++;
      $display("FAIL full_wrap_end olck0=%b oerr=%b expected 0 0", olck[0], oerr);
    end
  endtask

  task automatic test_mid_reset();
    irdy = 1'b0;
    send(1'b0, TYPE_HEAD, 29'h61, 1'b0);
    send(1'b0, TYPE_BODY, 29'h62, 1'b0);
    n_vec++;
    if (olck[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_lock olck0=%b expected 1", olck[0]);
    end
    #1;
    rst_ = 1'b1;
    #1;
    n_vec++;
    if (olck !== 2'b00 || ovalid !== 1'b0 || oack !== 2'b00 || odata !== 32'h0 || oerr !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async olck=%b ovalid=%b oack=%b odata=%h oerr=%b expected zeros",
               olck, ovalid, oack, odata, oerr);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    irdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (ovalid !== 1'b0 || oack !== 2'b00) begin
        n_err++;
        $display("FAIL midrst_discard cycle=%0d ovalid=%b oack=%b expected 0 00", i, ovalid, oack);
      end
    end
    send(1'b0, TYPE_HEADTAIL, 29'h71, 1'b1);
    n_vec++;
    if (olck[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_newhead olck0=%b expected 1", olck[0]);
    end
    wait_drain("mid_reset");
    n_vec++;
    if (olck[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_unlock olck0=%b expected 0", olck[0]);
    end
  endtask

  initial begin
    rst_   = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
    irdy   = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_interleave();
    test_overflow();
    test_reset();
    test_full_wrap();
    test_mid_reset();
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
